// File: rtl/lift_sched.sv
// rtl/lift_sched.sv - SCAN sequencing controller for a 3-floor lift
//
// Purpose: picks the next floor to serve, drives the motor commands, issues
// request clear strobes at each stop and times the door-open interval.
//
// Ports:
//   clk                 system clock, rising edge
//   resetb              synchronous reset, active high (1 = reset)
//   up0, up1            latched up hall calls, floors 0 and 1
//   dn1, dn2            latched down hall calls, floors 1 and 2
//   flreq0..flreq2      latched car floor requests
//   floorno[1:0]        floor the car is level with (2'b11 illegal)
//   upsig, dnsig        motor up / down command
//   moving              upsig | dnsig
//   clrup0, clrup1      up hall-call clear strobes
//   clrdn1, clrdn2      down hall-call clear strobes
//   clr_flreq0..2       car-request clear strobes
//   door_open           door-open indicator
//   dir_up              current scan direction (1 = up)
//   fault               sticky illegal-floor flag
module lift_sched #(
  parameter int START_DLY = 4,
  parameter int DOOR_CYC  = 16,
  parameter int CLR_LEN   = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       up0,
  input  logic       up1,
  input  logic       dn1,
  input  logic       dn2,
  input  logic       flreq0,
  input  logic       flreq1,
  input  logic       flreq2,
  input  logic [1:0] floorno,
  output logic       upsig,
  output logic       dnsig,
  output logic       moving,
  output logic       clrup0,
  output logic       clrup1,
  output logic       clrdn1,
  output logic       clrdn2,
  output logic       clr_flreq0,
  output logic       clr_flreq1,
  output logic       clr_flreq2,
  output logic       door_open,
  output logic       dir_up,
  output logic       fault
);

  localparam int MAX_A = (START_DLY > DOOR_CYC) ? START_DLY : DOOR_CYC;
  localparam int MAX_P = (MAX_A > CLR_LEN) ? MAX_A : CLR_LEN;
  localparam int CNT_W = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_MOVE_UP,
    S_MOVE_DN,
    S_STOP,
    S_DOOR,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic [1:0]       floor_q;
  logic             flip_q;
  logic [1:0]       clr_up_q;
  logic [2:1]       clr_dn_q;
  logic [2:0]       clr_fl_q;
  logic             door_hold_q;

  logic [2:0] up_v, dn_v, fl_v, any_v, f_oh;
  logic       illegal, arrived;
  logic       above, below, ahead;
  logic       here_up, here_dn, here_fl, here_serv;
  state_e     dec_state;
  logic       dec_dir;
  logic       enter_stop, flip_d;
  logic [1:0] cm_up;
  logic [2:1] cm_dn;

  // Per-floor request vectors; floor 2 has no up call, floor 0 no down call.
  assign up_v    = {1'b0, up1, up0};
  assign dn_v    = {dn2, dn1, 1'b0};
  assign fl_v    = {flreq2, flreq1, flreq0};
  assign any_v   = up_v | dn_v | fl_v;
  assign illegal = (floorno == 2'b11);
  assign arrived = (floorno != floor_q);

  always_comb begin
    f_oh  = 3'b000;
    above = 1'b0;
    below = 1'b0;
    case (floorno)
      2'd0: begin
        f_oh  = 3'b001;
        above = |any_v[2:1];
      end
      2'd1: begin
        f_oh  = 3'b010;
        above = any_v[2];
        below = any_v[0];
      end
      2'd2: begin
        f_oh  = 3'b100;
        below = |any_v[1:0];
      end
      default: ;
    endcase
  end

  assign here_up = |(up_v & f_oh);
  assign here_dn = |(dn_v & f_oh);
  assign here_fl = |(fl_v & f_oh);
  assign ahead   = dir_up_q ? above : below;

  // A hall call at this floor pointing against the scan direction is left
  // pending while work remains ahead; otherwise it would be re-served at
  // every door expiry without ever being cleared.
  assign here_serv = here_fl | (dir_up_q ? here_up : here_dn) |
                     (!ahead & (here_up | here_dn));

  // Where to go from rest (IDLE or door expiry).
  always_comb begin
    dec_state = S_IDLE;
    dec_dir   = dir_up_q;
    if (here_serv) begin
      dec_state = S_STOP;
    end else if (ahead) begin
      dec_state = S_START;
    end else if (above) begin
      dec_state = S_START;
      dec_dir   = 1'b1;
    end else if (below) begin
      dec_state = S_START;
      dec_dir   = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    case (state_q)
      S_IDLE: begin
        state_d  = dec_state;
        dir_up_d = dec_dir;
      end
      S_START: begin
        if (here_serv) begin
          state_d = S_STOP;
        end else if (cnt_q == CNT_W'(START_DLY - 1)) begin
          state_d = dir_up_q ? S_MOVE_UP : S_MOVE_DN;
        end
      end
      // End floors always stop: nothing lies beyond them.
      S_MOVE_UP: begin
        if (arrived && (here_serv || floorno == 2'd2)) state_d = S_STOP;
      end
      S_MOVE_DN: begin
        if (arrived && (here_serv || floorno == 2'd0)) state_d = S_STOP;
      end
      // The direction flip is applied on leaving STOP so the strobes are
      // seen alongside the direction the car arrived in.
      S_STOP: begin
        if (cnt_q == CNT_W'(CLR_LEN - 1)) begin
          state_d  = S_DOOR;
          dir_up_d = dir_up_q ^ flip_q;
        end
      end
      S_DOOR: begin
        if (here_serv) begin
          state_d = S_STOP;
        end else if (cnt_q == CNT_W'(DOOR_CYC - 1)) begin
          state_d  = dec_state;
          dir_up_d = dec_dir;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (illegal) begin
      state_d  = S_FAULT;
      dir_up_d = dir_up_q;
    end
  end

  // Clear set is frozen on entry to STOP from the requests seen then.
  assign enter_stop = (state_d == S_STOP) && (state_q != S_STOP);
  assign flip_d     = dir_up_q ? !above : !below;
  assign cm_up      = (dir_up_q || flip_d) ? f_oh[1:0] : 2'b00;
  assign cm_dn      = (!dir_up_q || flip_d) ? f_oh[2:1] : 2'b00;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_START || state_q == S_STOP || state_q == S_DOOR) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_up_q    <= 1'b1;
      floor_q     <= floorno;
      flip_q      <= 1'b0;
      clr_up_q    <= '0;
      clr_dn_q    <= '0;
      clr_fl_q    <= '0;
      door_hold_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      floor_q  <= floorno;
      if (enter_stop) begin
        clr_up_q    <= cm_up;
        clr_dn_q    <= cm_dn;
        clr_fl_q    <= f_oh;
        flip_q      <= flip_d;
        // Reopening from DOOR keeps the door indicator up through STOP.
        door_hold_q <= (state_q == S_DOOR);
      end
    end
  end

  assign upsig      = (state_q == S_MOVE_UP);
  assign dnsig      = (state_q == S_MOVE_DN);
  assign moving     = upsig | dnsig;
  assign clrup0     = (state_q == S_STOP) & clr_up_q[0];
  assign clrup1     = (state_q == S_STOP) & clr_up_q[1];
  assign clrdn1     = (state_q == S_STOP) & clr_dn_q[1];
  assign clrdn2     = (state_q == S_STOP) & clr_dn_q[2];
  assign clr_flreq0 = (state_q == S_STOP) & clr_fl_q[0];
  assign clr_flreq1 = (state_q == S_STOP) & clr_fl_q[1];
  assign clr_flreq2 = (state_q == S_STOP) & clr_fl_q[2];
  assign door_open  = (state_q == S_DOOR) | ((state_q == S_STOP) & door_hold_q);
  assign dir_up     = dir_up_q;
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_lift_sched.sv
// tb/tb_lift_sched.sv - self-checking bench for lift_sched
module tb_lift_sched;

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic       up0 = 0, up1 = 0, dn1 = 0, dn2 = 0;
  logic       fl0 = 0, fl1 = 0, fl2 = 0;
  logic [1:0] floorno = 2'd0;
  logic       upsig, dnsig, moving;
  logic       clrup0, clrup1, clrdn1, clrdn2;
  logic       clr_flreq0, clr_flreq1, clr_flreq2;
  logic       door_open, dir_up, fault;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   auto_move = 0;
  int   tc = 0;
  bit   pend_arr = 0;
  bit   arr_up = 0;
  logic [6:0] prev_clr = '0;
  int   ev_kind[$];
  int   ev_floor[$];
  bit   ev_dir[$];

  lift_sched dut (
    .clk(clk), .resetb(resetb),
    .up0(up0), .up1(up1), .dn1(dn1), .dn2(dn2),
    .flreq0(fl0), .flreq1(fl1), .flreq2(fl2),
    .floorno(floorno),
    .upsig(upsig), .dnsig(dnsig), .moving(moving),
    .clrup0(clrup0), .clrup1(clrup1), .clrdn1(clrdn1), .clrdn2(clrdn2),
    .clr_flreq0(clr_flreq0), .clr_flreq1(clr_flreq1), .clr_flreq2(clr_flreq2),
    .door_open(door_open), .dir_up(dir_up), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic bit req_at(int k);
    case (k)
      0: return up0 | fl0;
      1: return up1 | dn1 | fl1;
      2: return dn2 | fl2;
      default: return 1'b0;
    endcase
  endfunction

  // SCAN stop rule on arrival at floor f.
  function automatic bit model_stop(int f, bit going_up);
    bit fl_f, up_f, dn_f, ahead;
    fl_f  = (f == 0) ? fl0 : (f == 1) ? fl1 : fl2;
    up_f  = (f == 0) ? up0 : (f == 1) ? up1 : 1'b0;
    dn_f  = (f == 1) ? dn1 : (f == 2) ? dn2 : 1'b0;
    ahead = 1'b0;
    if (going_up) begin
      for (int k = f + 1; k <= 2; k++) ahead |= req_at(k);
      return (f == 2) || fl_f || up_f || (!ahead && req_at(f));
    end
    for (int k = 0; k < f; k++) ahead |= req_at(k);
    return (f == 0) || fl_f || dn_f || (!ahead && req_at(f));
  endfunction

  function automatic bit all_clear();
    return !(up0 | up1 | dn1 | dn2 | fl0 | fl1 | fl2);
  endfunction

  // One clock: edge, sample, environment (request latch + car travel).
  task automatic tick();
    bit         exp_stop, chk_stop;
    logic [2:0] grp, grp_exp;
    logic [6:0] cur;
    chk_stop = 0;
    exp_stop = 0;
    if (pend_arr) begin
      exp_stop = model_stop(int'(floorno), arr_up);
      chk_stop = 1;
      pend_arr = 0;
    end
    @(posedge clk);
    #1;
    if (chk_stop) begin
      n_checks++;
      if (moving !== !exp_stop) begin
        n_fail++;
        $display("FAIL scan_stop floor=%0d up=%0b moving=%b required=%b", floorno, arr_up, moving, !exp_stop);
      end
    end
    n_checks++;
    if ((upsig & dnsig) !== 1'b0 || moving !== (upsig | dnsig)) begin
      n_fail++;
      $display("FAIL motion_invariant upsig=%b dnsig=%b moving=%b", upsig, dnsig, moving);
    end
    grp = {clrdn2 | clr_flreq2, clrup1 | clrdn1 | clr_flreq1, clrup0 | clr_flreq0};
    if (grp !== 3'b000) begin
      n_checks++;
      grp_exp = 3'b001 << floorno;
      if (grp !== grp_exp || moving !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_at_floor groups=%b moving=%b required groups=%b moving=0", grp, moving, grp_exp);
      end
    end
    cur = {clr_flreq2, clr_flreq1, clr_flreq0, clrdn2, clrdn1, clrup1, clrup0};
    for (int k = 0; k < 7; k++) begin
      if (cur[k] === 1'b1 && prev_clr[k] !== 1'b1) begin
        ev_kind.push_back(k);
        ev_floor.push_back(int'(floorno));
        ev_dir.push_back(dir_up);
      end
    end
    prev_clr = cur;
    if (clrup0 === 1'b1) up0 = 0;
    if (clrup1 === 1'b1) up1 = 0;
    if (clrdn1 === 1'b1) dn1 = 0;
    if (clrdn2 === 1'b1) dn2 = 0;
    if (clr_flreq0 === 1'b1) fl0 = 0;
    if (clr_flreq1 === 1'b1) fl1 = 0;
    if (clr_flreq2 === 1'b1) fl2 = 0;
    if (auto_move) begin
      if (upsig === 1'b1 && floorno < 2) begin
        tc++;
        if (tc == 6) begin floorno = floorno + 2'd1; tc = 0; pend_arr = 1; arr_up = 1; end
      end else if (dnsig === 1'b1 && floorno > 0) begin
        tc++;
        if (tc == 6) begin floorno = floorno - 2'd1; tc = 0; pend_arr = 1; arr_up = 0; end
      end else begin
        tc = 0;
      end
    end
  endtask

  task automatic do_reset(input logic [1:0] f);
    {up0, up1, dn1, dn2, fl0, fl1, fl2} = '0;
    floorno   = f;
    auto_move = 0;
    tc        = 0;
    pend_arr  = 0;
    resetb    = 1;
    tick();
    resetb    = 0;
    ev_kind.delete();
    ev_floor.delete();
    ev_dir.delete();
  endtask

  task automatic wait_upsig(output bit ok);
    ok = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (upsig === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    do_reset(2'd0);
    outs = {upsig, dnsig, moving, clrup0, clrup1, clrdn1, clrdn2,
            clr_flreq0, clr_flreq1, clr_flreq2, door_open};
    n_checks++;
    if (outs !== '0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b fault=%b required all 0", outs, fault);
    end
    n_checks++;
    if (dir_up !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dir_up got=%b required=1", dir_up);
    end
    fl2    = 1;
    resetb = 1;
    tick();
    tick();
    n_checks++;
    if (moving !== 1'b0 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held moving=%b door_open=%b required 0 0", moving, door_open);
    end
    fl2    = 0;
    resetb = 0;
  endtask

  task automatic test_reset_mid_motion();
    bit ok;
    do_reset(2'd0);
    fl2 = 1;
    wait_upsig(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_reset_start upsig=%b required=1", upsig); end
    resetb = 1;
    tick();
    n_checks++;
    if (upsig !== 0 || moving !== 0 || dir_up !== 1 || door_open !== 0 ||
        {clrup0, clrup1, clrdn1, clrdn2, clr_flreq0, clr_flreq1, clr_flreq2} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset upsig=%b moving=%b dir_up=%b door=%b required 0 0 1 0", upsig, moving, dir_up, door_open);
    end
    fl2    = 0;
    resetb = 0;
  endtask

  task automatic test_car_call_up();
    bit early, dropped;
    int dc;
    do_reset(2'd0);
    fl2   = 1;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (upsig !== 1'b0) early = 1;
    end
    n_checks++;
    if (early) begin n_fail++; $display("FAIL start_delay upsig rose before 4 cycles"); end
    tick();
    n_checks++;
    if (upsig !== 1'b1) begin n_fail++; $display("FAIL start_rise upsig=%b required=1", upsig); end
    floorno = 2'd1;
    dropped = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (upsig !== 1'b1) dropped = 1;
    end
    n_checks++;
    if (dropped) begin n_fail++; $display("FAIL pass_floor1 upsig dropped, required to stay 1"); end
    floorno = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (upsig !== 0 || clr_flreq2 !== 1 || clrdn2 !== 1) begin
        n_fail++;
        $display("FAIL stop_floor2 cyc=%0d upsig=%b clr_flreq2=%b clrdn2=%b required 0 1 1", i, upsig, clr_flreq2, clrdn2);
      end
    end
    tick();
    n_checks++;
    if (door_open !== 1 || dir_up !== 0 || clr_flreq2 !== 0 || clrdn2 !== 0) begin
      n_fail++;
      $display("FAIL door_floor2 door=%b dir_up=%b clr=%b%b required 1 0 00", door_open, dir_up, clr_flreq2, clrdn2);
    end
    dc = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (door_open === 1'b1) dc++;
      else break;
    end
    n_checks++;
    if (dc != 16) begin n_fail++; $display("FAIL door_len got=%0d required=16", dc); end
    tick();
    n_checks++;
    if (moving !== 0 || door_open !== 0) begin
      n_fail++;
      $display("FAIL idle_after moving=%b door=%b required 0 0", moving, door_open);
    end
  endtask

  task automatic test_hall_here();
    bit any_move;
    int dc;
    do_reset(2'd1);
    dn1      = 1;
    any_move = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (moving !== 1'b0) any_move = 1;
      n_checks++;
      if (clrdn1 !== 1'b1) begin n_fail++; $display("FAIL hall_clr cyc=%0d clrdn1=%b required=1", i, clrdn1); end
    end
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (moving !== 1'b0) any_move = 1;
      if (door_open === 1'b1) dc++;
      else break;
    end
    n_checks++;
    if (dc != 16) begin n_fail++; $display("FAIL hall_door_len got=%0d required=16", dc); end
    n_checks++;
    if (any_move) begin n_fail++; $display("FAIL hall_no_motion moving seen=1 required=0"); end
  endtask

  task automatic test_scan_order();
    bit raised, done;
    int i1, i2, i3;
    do_reset(2'd0);
    auto_move = 1;
    fl1       = 1;
    fl2       = 1;
    raised    = 0;
    done      = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (!raised && floorno == 2'd2 && door_open === 1'b1) begin dn1 = 1; raised = 1; end
      if (raised && all_clear() && moving === 1'b0 && door_open === 1'b0) done = 1;
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL scan_drain timeout raised=%0b", raised); end
    i1 = -1; i2 = -1; i3 = -1;
    foreach (ev_kind[i]) begin
      if (ev_kind[i] == 5 && i1 < 0) i1 = i;
      if (ev_kind[i] == 6 && i2 < 0) i2 = i;
      if (ev_kind[i] == 2 && i3 < 0) i3 = i;
    end
    n_checks++;
    if (!(i1 >= 0 && i2 > i1 && i3 > i2)) begin
      n_fail++;
      $display("FAIL scan_order idx fl1=%0d fl2=%0d dn1=%0d required increasing", i1, i2, i3);
    end
    n_checks++;
    if (i3 < 0 || ev_floor[i3] != 1 || ev_dir[i3] !== 1'b0) begin
      n_fail++;
      $display("FAIL dn1_after_reversal idx=%0d required floor 1 dir_up 0", i3);
    end
    auto_move = 0;
  endtask

  task automatic test_door_ext();
    bit ok, seen;
    int dc, post;
    do_reset(2'd1);
    fl1 = 1;
    ok  = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (door_open === 1'b1) ok = 1;
    end
    dc = ok ? 1 : 0;
    for (int i = 0; i < 20 && dc < 10; i++) begin
      tick();
      if (door_open === 1'b1) dc++;
      else break;
    end
    n_checks++;
    if (dc != 10) begin n_fail++; $display("FAIL door_ext_pre got=%0d required=10", dc); end
    fl1  = 1;
    seen = 0;
    post = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (door_open !== 1'b1) break;
      if (clr_flreq1 === 1'b1) seen = 1;
      else if (seen) post++;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL door_ext_clr clr_flreq1 not seen with door held, required pulse"); end
    n_checks++;
    if (post != 16) begin n_fail++; $display("FAIL door_ext_len got=%0d required=16", post); end
  endtask

  task automatic test_fault();
    bit ok, lost;
    do_reset(2'd0);
    fl2 = 1;
    wait_upsig(ok);
    floorno = 2'b11;
    tick();
    n_checks++;
    if (!ok || moving !== 0 || fault !== 1) begin
      n_fail++;
      $display("FAIL fault_entry moving=%b fault=%b required 0 1", moving, fault);
    end
    floorno = 2'd0;
    fl2     = 0;
    lost    = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fault !== 1'b1 || moving !== 1'b0) lost = 1;
    end
    n_checks++;
    if (lost) begin n_fail++; $display("FAIL fault_sticky fault=%b required=1", fault); end
    resetb = 1;
    tick();
    resetb = 0;
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_reset fault=%b required=0", fault); end
  endtask

  task automatic test_random();
    bit done;
    do_reset(2'($urandom_range(0, 2)));
    auto_move = 1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 6))
          0: up0 = 1;
          1: up1 = 1;
          2: dn1 = 1;
          3: dn2 = 1;
          4: fl0 = 1;
          5: fl1 = 1;
          default: fl2 = 1;
        endcase
      end
    end
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (all_clear() && moving === 1'b0 && door_open === 1'b0) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL random_drain flags=%b%b%b%b%b%b%b required all served", up0, up1, dn1, dn2, fl0, fl1, fl2);
    end
    auto_move = 0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_motion();
    test_car_call_up();
    test_hall_here();
    test_scan_order();
    test_door_ext();
    test_fault();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
